riscv_wb: RTL and testbench
===========================

# riscv_wb

Writeback stage of the RV12 pipeline. It accepts retiring instructions from the memory stage, waits for data-memory responses on loads, and aligns and sign/zero-extends load data. It drives the single register-file write port (`rf_dst`/`rf_dstv`/`rf_we`, port 0) and reports faults to the state/exception logic.

## Interface
Parameters:
- `XLEN`, 32, datapath width (32 only supported).
- `AR_BITS`, 5, register-address width.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `rstn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: memory stage presents an instruction.
- `mem_ready` out 1: writeback accepts it this cycle.
- `mem_pc` in XLEN: instruction PC.
- `mem_rd` in AR_BITS: destination register.
- `mem_rd_we` in 1: instruction writes `rd`.
- `mem_is_load` in 1: instruction is a load; result comes from dmem.
- `mem_ld_size` in 3: funct3; 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_addr_lsb` in 2: load address bits [1:0].
- `mem_result` in XLEN: ALU/CSR result for non-loads.
- `mem_exception` in 1: upstream fault; suppresses the write.
- `dmem_ack` in 1: load data valid.
- `dmem_err` in 1: bus error on the load.
- `dmem_rdata` in XLEN: raw load word.
- `du_stall` in 1: debug stall; blocks acceptance.
- `rf_dst` out AR_BITS: write address.
- `rf_dstv` out XLEN: write data.
- `rf_we` out 1: write strobe, one-cycle pulse.
- `wb_exception` out 1: fault pulse.
- `wb_pc` out XLEN: PC of the retired or faulting instruction.
- `wb_busy` out 1: load outstanding.

## Operation
- FSM states are IDLE and LOAD.
- `mem_ready` = (state==IDLE) & ~`du_stall`. Transfer occurs when `mem_valid` & `mem_ready`.
- Non-load transfer:
  - Next cycle, `rf_dstv`=`mem_result`, `rf_dst`=`mem_rd`, `wb_pc`=`mem_pc`.
  - `rf_we`=`mem_rd_we` & (`mem_rd`!=0) & ~`mem_exception`.
  - `wb_exception`=`mem_exception`.
- Load transfer with `mem_exception`=0:
  - Latch rd, rd_we, size, lsb and pc. Go to LOAD; `wb_busy`=1.
- Load transfer with `mem_exception`=1:
  - Treated as a non-load fault. No LOAD entry, no write.
- In LOAD:
  - On `dmem_ack` or `dmem_err`, return to IDLE.
  - Next cycle, write the extracted data (rules below) unless `dmem_err` or rd==0.
  - `dmem_err` gives `wb_exception`=1 and no write. `dmem_err` wins over a simultaneous `dmem_ack`.
- Extraction:
  - byte = `dmem_rdata`[8*lsb+:8]; half = `dmem_rdata`[16*lsb[1]+:16].
  - LB/LH sign-extend to XLEN. LBU/LHU zero-extend. LW passes the word.
  - Unlisted size codes behave as LW.
- `dmem_ack`/`dmem_err` in IDLE are ignored.
- `du_stall` does not abort an outstanding load; the response is still captured and written.
- `rf_we` and `wb_exception` are never both 1.

## Timing
- Reset values:
  - state=IDLE; `mem_ready`=~`du_stall` (0 while `rstn`=0).
  - `rf_we`=0, `wb_exception`=0, `wb_busy`=0.
  - `rf_dst`=0, `rf_dstv`=0, `wb_pc`=0.
- Non-load latency: accept in cycle N gives `rf_we` in N+1. Throughput is 1 per cycle.
- Load latency: `dmem_ack` in cycle M gives `rf_we` in M+1. `mem_ready` rises in M+1, so there is at least one bubble after each load.
- A response arriving in the accept cycle itself is ignored; the response must come at least 1 cycle after acceptance.
- Reset asserted mid-load: return to IDLE with no write. A later stale ack in IDLE is ignored.
- All outputs are registered except `mem_ready`.

## Configuration
- Macro `RV12_WB_MISALIGN_CHK_EN` defined:
  - LH/LHU with lsb[0]=1, or LW with lsb!=0, raises `wb_exception` with no write.
  - The exception is reported in the cycle after the response, so the bus is still drained.
- Macro undefined: misaligned offsets are aligned down (lsb[0] ignored for halves, lsb ignored for words), then extracted normally.

## Structure
- Shared package `riscv_pkg` holds:
  - load-size constants LB/LH/LW/LBU/LHU;
  - the `wb_state_t` enum (IDLE, LOAD).
- Combinational sub-module `riscv_wb_ldext` holds the size/lsb extraction and extension, plus the misalign flag under the macro.
- FSM and output registers stay in `riscv_wb`.

## Test plan
- Back-to-back non-loads: rd=5 value 0x1234, then rd=0 value 0xFFFF → `rf_we` 1 then 0. `rf_dst`=5 and `rf_dstv`=0x1234 in the first write cycle. `mem_ready` held 1.
- LB, lsb=3, rdata=0x80FF_0000 → `rf_dstv`=0xFFFF_FF80. Same with LBU → 0x0000_0080. Each written 1 cycle after ack.
- LH, lsb=2, rdata=0x8001_7FFF, ack after 4 wait cycles → `wb_busy` 1 for 4 cycles, `mem_ready` 0, then `rf_dstv`=0xFFFF_8001.
- `dmem_ack` and `dmem_err` together on LW → `wb_exception`=1, `wb_pc`=load PC, `rf_we`=0. Next instruction accepted the following cycle.
- `du_stall` asserted during an outstanding LW (rdata 0xDEADBEEF) → write still occurs. `mem_ready` stays 0 until `du_stall` drops.
- `rstn` pulsed low mid-LOAD, followed by a stale ack → no `rf_we`, all outputs 0. With `RV12_WB_MISALIGN_CHK_EN`, LW lsb=1 → exception and no write; without it → aligned word written.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV12 writeback stage: load-size codes (funct3)
// and the writeback FSM state type.
package riscv_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/riscv_wb_ldext.sv
// Load-data extraction: selects the byte/half/word addressed by lsb and
// sign- or zero-extends it to XLEN.
// Optional macro RV12_WB_MISALIGN_CHK_EN: flags misaligned half/word loads
// instead of silently aligning them down.
module riscv_wb_ldext
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      size,
  input  logic [1:0]      lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  b_val;
  logic [15:0] h_val;

  // Lane select and extension; halves use only lsb[1], words ignore lsb,
  // which is what aligns misaligned offsets down.
  always_comb begin
    b_val    = rdata[{lsb, 3'b000} +: 8];
    h_val    = rdata[{lsb[1], 4'b0000} +: 16];
    data     = rdata;
    misalign = 1'b0;
    case (size)
      LB:  data = {{(XLEN-8){b_val[7]}}, b_val};
      LBU: data = {{(XLEN-8){1'b0}}, b_val};
      LH:  data = {{(XLEN-16){h_val[15]}}, h_val};
      LHU: data = {{(XLEN-16){1'b0}}, h_val};
      default: data = rdata;
    endcase
`ifdef RV12_WB_MISALIGN_CHK_EN
    case (size)
      LB, LBU:  misalign = 1'b0;
      LH, LHU:  misalign = lsb[0];
      default:  misalign = (lsb != 2'b00);
    endcase
`endif
  end

endmodule

// File: rtl/riscv_wb.sv
// RV12 writeback stage: retires instructions from the memory stage, waits
// for dmem responses on loads and drives register-file write port 0.
// Optional macro RV12_WB_MISALIGN_CHK_EN (see riscv_wb_ldext).
//
// state | meaning
// IDLE  | ready to accept an instruction from the memory stage
// LOAD  | load accepted, waiting for dmem_ack / dmem_err
module riscv_wb
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic [AR_BITS-1:0] mem_rd,
  input  logic               mem_rd_we,
  input  logic               mem_is_load,
  input  logic [2:0]         mem_ld_size,
  input  logic [1:0]         mem_addr_lsb,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               mem_exception,
  input  logic               dmem_ack,
  input  logic               dmem_err,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               du_stall,
  output logic [AR_BITS-1:0] rf_dst,
  output logic [XLEN-1:0]    rf_dstv,
  output logic               rf_we,
  output logic               wb_exception,
  output logic [XLEN-1:0]    wb_pc,
  output logic               wb_busy
);

  wb_state_t          state, state_nxt;
  logic [AR_BITS-1:0] ld_rd;
  logic               ld_rd_we;
  logic [2:0]         ld_size;
  logic [1:0]         ld_lsb;
  logic [XLEN-1:0]    ld_pc;
  logic [XLEN-1:0]    ld_data;
  logic               ld_misalign;
  logic               xfer;

  logic [AR_BITS-1:0] dst_nxt;
  logic [XLEN-1:0]    dstv_nxt;
  logic [XLEN-1:0]    pc_nxt;
  logic               we_nxt;
  logic               exc_nxt;

  // Acceptance is held off during reset so nothing transfers before release.
  assign mem_ready = rstn & (state == IDLE) & ~du_stall;
  assign xfer      = mem_valid & mem_ready;
  assign wb_busy   = (state == LOAD);

  riscv_wb_ldext #(.XLEN(XLEN)) u_ldext (
    .size     (ld_size),
    .lsb      (ld_lsb),
    .rdata    (dmem_rdata),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // Next state and next values of the registered writeback outputs.
  always_comb begin
    state_nxt = state;
    dst_nxt   = rf_dst;
    dstv_nxt  = rf_dstv;
    pc_nxt    = wb_pc;
    we_nxt    = 1'b0;
    exc_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (mem_is_load && !mem_exception) begin
            state_nxt = LOAD;
          end else begin
            // A faulting load is retired as a plain fault, no bus wait.
            dst_nxt  = mem_rd;
            dstv_nxt = mem_result;
            pc_nxt   = mem_pc;
            we_nxt   = mem_rd_we & (mem_rd != '0) & ~mem_exception;
            exc_nxt  = mem_exception;
          end
        end
      end
      LOAD: begin
        if (dmem_ack || dmem_err) begin
          state_nxt = IDLE;
          dst_nxt   = ld_rd;
          dstv_nxt  = ld_data;
          pc_nxt    = ld_pc;
          // Bus error takes priority over a simultaneous ack.
          if (dmem_err || ld_misalign) begin
            exc_nxt = 1'b1;
          end else begin
            we_nxt = ld_rd_we & (ld_rd != '0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered write-port / fault outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      rf_dst       <= '0;
      rf_dstv      <= '0;
      wb_pc        <= '0;
      rf_we        <= 1'b0;
      wb_exception <= 1'b0;
    end else begin
      state        <= state_nxt;
      rf_dst       <= dst_nxt;
      rf_dstv      <= dstv_nxt;
      wb_pc        <= pc_nxt;
      rf_we        <= we_nxt;
      wb_exception <= exc_nxt;
    end
  end

  // Load context captured at acceptance, used when the response returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_rd    <= '0;
      ld_rd_we <= 1'b0;
      ld_size  <= LW;
      ld_lsb   <= 2'b00;
      ld_pc    <= '0;
    end else if (xfer) begin
      ld_rd    <= mem_rd;
      ld_rd_we <= mem_rd_we;
      ld_size  <= mem_ld_size;
      ld_lsb   <= mem_addr_lsb;
      ld_pc    <= mem_pc;
    end
  end

endmodule

// File: tb/tb_riscv_wb.sv
// Scoreboard bench for riscv_wb: stimulus pushes expected write/fault
// events, a negedge monitor pops and compares whenever rf_we or
// wb_exception is asserted.
module tb_riscv_wb;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_pc;
  logic [4:0]  mem_rd;
  logic        mem_rd_we, mem_is_load;
  logic [2:0]  mem_ld_size;
  logic [1:0]  mem_addr_lsb;
  logic [31:0] mem_result;
  logic        mem_exception;
  logic        dmem_ack, dmem_err;
  logic [31:0] dmem_rdata;
  logic        du_stall;
  logic [4:0]  rf_dst;
  logic [31:0] rf_dstv;
  logic        rf_we, wb_exception;
  logic [31:0] wb_pc;
  logic        wb_busy;

  typedef struct {
    logic        exc;
    logic [4:0]  dst;
    logic [31:0] dstv;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  riscv_wb #(.XLEN(32), .AR_BITS(5)) dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc),
    .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
    .mem_ld_size(mem_ld_size), .mem_addr_lsb(mem_addr_lsb),
    .mem_result(mem_result), .mem_exception(mem_exception),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .du_stall(du_stall), .rf_dst(rf_dst), .rf_dstv(rf_dstv), .rf_we(rf_we),
    .wb_exception(wb_exception), .wb_pc(wb_pc), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic exc, input logic [4:0] dst, input logic [31:0] dstv,
                      input logic [31:0] pc);
    exp_t e;
    e.exc = exc; e.dst = dst; e.dstv = dstv; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [2:0] sz, input logic [1:0] lsb,
                       input logic [31:0] res, input logic exc);
    mem_valid = 1'b1; mem_pc = pc; mem_rd = rd; mem_rd_we = we; mem_is_load = ld;
    mem_ld_size = sz; mem_addr_lsb = lsb; mem_result = res; mem_exception = exc;
    #1;
    chk("mem_ready_at_issue", {31'd0, mem_ready}, 32'd1);
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic respond(input logic ack, input logic err, input logic [31:0] rdata);
    dmem_ack = ack; dmem_err = err; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0; dmem_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"},  {31'd0, rf_we}, 32'd0);
    chk({tag, "_wb_exc"}, {31'd0, wb_exception}, 32'd0);
    chk({tag, "_busy"},   {31'd0, wb_busy}, 32'd0);
    chk({tag, "_rf_dst"}, {27'd0, rf_dst}, 32'd0);
    chk({tag, "_rf_dstv"}, rf_dstv, 32'd0);
    chk({tag, "_wb_pc"},  wb_pc, 32'd0);
  endtask

  // Monitor: every write or fault pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (rf_we === 1'b1 || wb_exception === 1'b1)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output we=%b exc=%b dst=%0d dstv=%h pc=%h required=none",
                 rf_we, wb_exception, rf_dst, rf_dstv, wb_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", {30'd0, rf_we, wb_exception}, e.exc ? 32'd1 : 32'd2);
        chk("sb_pc", wb_pc, e.pc);
        if (!e.exc) begin
          chk("sb_dst", {27'd0, rf_dst}, {27'd0, e.dst});
          chk("sb_dstv", rf_dstv, e.dstv);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; mem_valid = 1'b0; mem_pc = '0; mem_rd = '0; mem_rd_we = 1'b0;
    mem_is_load = 1'b0; mem_ld_size = LW; mem_addr_lsb = 2'b00; mem_result = '0;
    mem_exception = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    du_stall = 1'b0;
    #12;
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk_all_zero("rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("idle_mem_ready", {31'd0, mem_ready}, 32'd1);

    // Back-to-back non-loads; rd=0 must not write.
    push(1'b0, 5'd5, 32'h0000_1234, 32'h100);
    issue(32'h100, 5'd5, 1'b1, 1'b0, LW, 2'd0, 32'h0000_1234, 1'b0);
    chk("nl1_rf_we", {31'd0, rf_we}, 32'd1);
    chk("nl1_rf_dst", {27'd0, rf_dst}, 32'd5);
    chk("nl1_rf_dstv", rf_dstv, 32'h0000_1234);
    issue(32'h104, 5'd0, 1'b1, 1'b0, LW, 2'd0, 32'h0000_FFFF, 1'b0);
    chk("nl2_rf_we", {31'd0, rf_we}, 32'd0);

    // LB / LBU at lsb=3.
    issue(32'h200, 5'd6, 1'b1, 1'b1, LB, 2'd3, 32'h0, 1'b0);
    chk("lb_busy", {31'd0, wb_busy}, 32'd1);
    chk("lb_ready", {31'd0, mem_ready}, 32'd0);
    push(1'b0, 5'd6, 32'hFFFF_FF80, 32'h200);
    respond(1'b1, 1'b0, 32'h80FF_0000);
    chk("lb_we_lat", {31'd0, rf_we}, 32'd1);
    issue(32'h204, 5'd7, 1'b1, 1'b1, LBU, 2'd3, 32'h0, 1'b0);
    push(1'b0, 5'd7, 32'h0000_0080, 32'h204);
    respond(1'b1, 1'b0, 32'h80FF_0000);
    chk("lbu_we_lat", {31'd0, rf_we}, 32'd1);

    // LH at lsb=2 with 4 wait cycles.
    issue(32'h208, 5'd8, 1'b1, 1'b1, LH, 2'd2, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("lh_wait_busy", {31'd0, wb_busy}, 32'd1);
      chk("lh_wait_ready", {31'd0, mem_ready}, 32'd0);
      tick();
    end
    push(1'b0, 5'd8, 32'hFFFF_8001, 32'h208);
    respond(1'b1, 1'b0, 32'h8001_7FFF);
    chk("lh_we_lat", {31'd0, rf_we}, 32'd1);

    // Simultaneous ack and err on LW: error wins.
    issue(32'h20C, 5'd9, 1'b1, 1'b1, LW, 2'd0, 32'h0, 1'b0);
    tick();
    push(1'b1, 5'd0, 32'h0, 32'h20C);
    respond(1'b1, 1'b1, 32'h1234_5678);
    chk("err_rf_we", {31'd0, rf_we}, 32'd0);
    chk("err_wb_exc", {31'd0, wb_exception}, 32'd1);
    push(1'b0, 5'd10, 32'h0000_0055, 32'h210);
    issue(32'h210, 5'd10, 1'b1, 1'b0, LW, 2'd0, 32'h0000_0055, 1'b0);

    // Faulting load is retired immediately as a fault.
    push(1'b1, 5'd0, 32'h0, 32'h220);
    issue(32'h220, 5'd14, 1'b1, 1'b1, LB, 2'd0, 32'h77, 1'b1);
    chk("ldexc_busy", {31'd0, wb_busy}, 32'd0);
    chk("ldexc_ready", {31'd0, mem_ready}, 32'd1);

    // du_stall during an outstanding load.
    issue(32'h214, 5'd11, 1'b1, 1'b1, LW, 2'd0, 32'h0, 1'b0);
    du_stall = 1'b1;
    tick();
    tick();
    push(1'b0, 5'd11, 32'hDEAD_BEEF, 32'h214);
    respond(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("stall_rf_we", {31'd0, rf_we}, 32'd1);
    chk("stall_ready0", {31'd0, mem_ready}, 32'd0);
    tick();
    chk("stall_ready1", {31'd0, mem_ready}, 32'd0);
    du_stall = 1'b0;
    #1;
    chk("stall_release_ready", {31'd0, mem_ready}, 32'd1);

    // Reset mid-load, then a stale ack.
    issue(32'h218, 5'd12, 1'b1, 1'b1, LW, 2'd0, 32'h0, 1'b0);
    tick();
    rstn = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, mem_ready}, 32'd0);
    chk_all_zero("midrst");
    tick();
    rstn = 1'b1;
    tick();
    respond(1'b1, 1'b0, 32'hCAFE_F00D);
    chk_all_zero("stale");

    // Misaligned LW at lsb=1.
    issue(32'h21C, 5'd13, 1'b1, 1'b1, LW, 2'd1, 32'h0, 1'b0);
    tick();
`ifdef RV12_WB_MISALIGN_CHK_EN
    push(1'b1, 5'd0, 32'h0, 32'h21C);
    respond(1'b1, 1'b0, 32'h1122_3344);
    chk("mis_rf_we", {31'd0, rf_we}, 32'd0);
`else
    push(1'b0, 5'd13, 32'h1122_3344, 32'h21C);
    respond(1'b1, 1'b0, 32'h1122_3344);
    chk("mis_rf_we", {31'd0, rf_we}, 32'd1);
`endif

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
